// File: rtl/gate_sweep_if.sv
// Control/result bundle between a test controller and the gate sweep checker.
// The checker drives the gate-under-test inputs (stim) and reads its output (dut_F).
interface gate_sweep_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [2:0]       mode;
    logic [N_IN-1:0]  stim;
    logic             dut_F;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [N_IN-1:0]  first_err_vec;
    logic             first_err_valid;

    modport master (
        output start, mode, dut_F,
        input  stim, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, mode, dut_F,
        output stim, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweeper for an N-input combinational gate; checks the gate output
// against a selected reference function and reports pass, mismatch count and first failure.
module gate_sweep_checker #(
    parameter int unsigned N_IN        = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic         clk,
    input logic         rst,
    gate_sweep_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [7:0]        hold_q, hold_d;
    logic [2:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic              fvalid_q, fvalid_d;
    logic              seen_q, seen_d;
    logic              pass_q, pass_d;
    logic              exp_f;
    logic              sample;
    logic              mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            stim_q   <= '0;
            hold_q   <= '0;
            mode_q   <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
            seen_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            hold_q   <= hold_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
            seen_q   <= seen_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        exp_f = 1'b0;
        case (mode_q)
            3'd0:    exp_f = &stim_q;
            3'd1:    exp_f = |stim_q;
            3'd2:    exp_f = ~&stim_q;
            3'd3:    exp_f = ~|stim_q;
            3'd4:    exp_f = ^stim_q;
            3'd5:    exp_f = ~^stim_q;
            3'd6:    exp_f = 1'b0;
            default: exp_f = 1'b1;
        endcase
    end

    assign sample   = (state_q == StDrive) && (hold_q == 8'(HOLD_CYCLES - 1));
    assign mismatch = sample && (bus.dut_F != exp_f);

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        hold_d   = hold_q;
        mode_d   = mode_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        seen_d   = seen_q;
        pass_d   = pass_q;

        case (state_q)
            StIdle: begin
                stim_d = '0;
                if (bus.start) begin
                    mode_d   = bus.mode;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    seen_d   = 1'b0;
                    pass_d   = 1'b0;
                    hold_d   = '0;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                hold_d = hold_q + 8'd1;
                if (mismatch) begin
                    seen_d = 1'b1;
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!fvalid_q) begin
                        fvec_d   = stim_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (sample) begin
                    hold_d = '0;
                    if (stim_q == {N_IN{1'b1}}) begin
                        // Sticky flag, not err_count, decides pass so saturation can't hide errors.
                        pass_d  = !(seen_q || mismatch);
                        state_d = StDone;
                    end else begin
                        stim_d = stim_q + N_IN'(1);
                    end
                end
            end
            StDone: begin
                stim_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.stim            = stim_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.done            = (state_q == StDone);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = fvec_q;
    assign bus.first_err_valid = fvalid_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: three checker instances with behavioural truth-table gates,
// results compared against a bit-counting reference model.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tt0 = 8'h00;
    logic [7:0] tt1 = 8'hFF;
    logic [3:0] tt2 = 4'b1001;

    gate_sweep_if #(.N_IN(3), .CNT_W(8)) bus0 ();
    gate_sweep_if #(.N_IN(3), .CNT_W(2)) bus1 ();
    gate_sweep_if #(.N_IN(2), .CNT_W(8)) bus2 ();

    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(4), .CNT_W(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
    gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1), .CNT_W(8)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Behavioural gates under test: arbitrary truth tables indexed by the stimulus.
    always_comb bus0.dut_F = tt0[bus0.stim];
    always_comb bus1.dut_F = tt1[bus1.stim];
    always_comb bus2.dut_F = tt2[bus2.stim];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_f(input logic [2:0] md, input int v, input int n);
        int ones;
        ones = $countones(v);
        case (md)
            3'd0:    return ones == n;
            3'd1:    return ones != 0;
            3'd2:    return ones != n;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            3'd6:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on instance 0; pulse_at >= 0 injects an ignored start pulse at that cycle.
    task automatic sweep0(input logic [2:0] md, input logic [7:0] tt, input int pulse_at);
        int errs, first, cyc;
        errs  = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (tt[v] != ref_f(md, v, 3)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        tt0 = tt;
        bus0.mode  = md;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.mode  = 3'($urandom_range(0, 7));
        cyc = 0;
        while (bus0.done !== 1'b1 && cyc < 40) begin
            if (cyc < 32) check("stim", 32'(bus0.stim), 32'(cyc / 4));
            check("busy_high", 32'(bus0.busy), 32'd1);
            bus0.start = (cyc == pulse_at);
            tick();
            cyc++;
        end
        bus0.start = 1'b0;
        check("done_cycle", cyc, 32);
        check("err_count", 32'(bus0.err_count), 32'((errs > 255) ? 255 : errs));
        check("pass", 32'(bus0.pass), 32'(errs == 0));
        check("first_err_valid", 32'(bus0.first_err_valid), 32'(first >= 0));
        check("first_err_vec", 32'(bus0.first_err_vec), 32'((first < 0) ? 0 : first));
        tick();
        check("busy_fall", 32'(bus0.busy), 32'd0);
        check("done_pulse", 32'(bus0.done), 32'd0);
        check("stim_idle", 32'(bus0.stim), 32'd0);
        check("pass_held", 32'(bus0.pass), 32'(errs == 0));
    endtask

    initial begin
        int cyc;
        bus0.start = 1'b0; bus0.mode = 3'd0;
        bus1.start = 1'b0; bus1.mode = 3'd0;
        bus2.start = 1'b0; bus2.mode = 3'd0;
        #2;
        check("rst_stim", 32'(bus0.stim), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'(bus0.done), 32'd0);
        check("rst_pass", 32'(bus0.pass), 32'd0);
        check("rst_err", 32'(bus0.err_count), 32'd0);
        check("rst_fvec", 32'(bus0.first_err_vec), 32'd0);
        check("rst_fvalid", 32'(bus0.first_err_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Correct NAND, NAND stuck-at-1, XOR expected vs NAND gate (ignored start pulse)
        sweep0(3'd2, 8'h7F, -1);
        sweep0(3'd2, 8'hFF, -1);
        check("stuck_fvec", 32'(bus0.first_err_vec), 32'd7);
        sweep0(3'd4, 8'h7F, 10);
        check("xor_err", 32'(bus0.err_count), 32'd5);

        // Mid-sweep asynchronous reset
        tt0 = 8'h7F;
        bus0.mode  = 3'd4;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check("pre_rst_err", 32'(bus0.err_count), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stim", 32'(bus0.stim), 32'd0);
        check("mid_rst_busy", 32'(bus0.busy), 32'd0);
        check("mid_rst_done", 32'(bus0.done), 32'd0);
        check("mid_rst_err", 32'(bus0.err_count), 32'd0);
        check("mid_rst_fvec", 32'(bus0.first_err_vec), 32'd0);
        check("mid_rst_fvalid", 32'(bus0.first_err_valid), 32'd0);
        check("mid_rst_pass", 32'(bus0.pass), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done_after_rst", 32'(bus0.done), 32'd0);
        end
        sweep0(3'd2, 8'h7F, -1);

        // Randomised gate/mode pairs
        for (int r = 0; r < 6; r++) begin
            sweep0(3'($urandom_range(0, 7)), 8'($urandom), -1);
        end

        // Saturating counter with CNT_W = 2: AND expected, stuck-at-1 gate
        bus1.mode  = 3'd0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 0;
        while (bus1.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("sat_done_cycle", cyc, 32);
        check("sat_err", 32'(bus1.err_count), 32'd3);
        check("sat_pass", 32'(bus1.pass), 32'd0);
        check("sat_fvec", 32'(bus1.first_err_vec), 32'd0);
        check("sat_fvalid", 32'(bus1.first_err_valid), 32'd1);

        // N_IN = 2, HOLD_CYCLES = 1, XNOR; start held high to chain a second sweep
        bus2.mode  = 3'd5;
        bus2.start = 1'b1;
        tick();
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 10) begin
            check("small_stim", 32'(bus2.stim), 32'(cyc));
            tick();
            cyc++;
        end
        check("small_done_cycle", cyc, 4);
        check("small_pass", 32'(bus2.pass), 32'd1);
        tick();
        check("small_idle_gap", 32'(bus2.busy), 32'd0);
        tick();
        check("small_restart", 32'(bus2.busy), 32'd1);
        check("small_restart_stim", 32'(bus2.stim), 32'd0);
        check("small_restart_pass_clr", 32'(bus2.pass), 32'd0);
        bus2.start = 1'b0;
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("small_done_cycle2", cyc, 4);
        check("small_pass2", 32'(bus2.pass), 32'd1);
        check("small_err2", 32'(bus2.err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
